// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port (MAR/MDR/EN/RW/MFC) with MFC timeout.
// Define ARB_RR_EN for round-robin arbitration; the default build is fixed priority (req[1] wins).
module mem_port_arbiter #(
  parameter int unsigned AW      = 6,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    rw,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_EN,
  output logic          mem_RW,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          MFC
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_timer;
  logic [1:0]  w_win;
  logic        w_timeout;

`ifdef ARB_RR_EN
  logic r_ptr;

  always_comb begin
    w_win = 2'b00;
    if (req == 2'b11)  w_win = r_ptr ? 2'b10 : 2'b01;
    else if (req[1])   w_win = 2'b10;
    else if (req[0])   w_win = 2'b01;
  end
`else
  always_comb begin
    w_win = 2'b00;
    if (req[1])        w_win = 2'b10;
    else if (req[0])   w_win = 2'b01;
  end
`endif

  // r_timer counts completed ACCESS cycles, so this is the TIMEOUT-th one.
  assign w_timeout = ((r_timer + 8'd1) == LP_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      gnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_EN    <= 1'b0;
      mem_RW    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_RR_EN
      r_ptr     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          ack    <= '0;
          err    <= 1'b0;
          mem_EN <= 1'b0;
          if (w_win != 2'b00) begin
            gnt       <= w_win;
            mem_RW    <= w_win[1] ? rw[1]  : rw[0];
            mem_addr  <= w_win[1] ? addr1  : addr0;
            mem_wdata <= w_win[1] ? wdata1 : wdata0;
            mem_EN    <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_ACCESS;
          end else begin
            gnt       <= '0;
            mem_RW    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        S_ACCESS: begin
          r_timer <= r_timer + 8'd1;
          // MFC takes precedence over an expiring timer in the same cycle.
          if (MFC) begin
            if (mem_RW) rdata <= mem_rdata;
            mem_EN  <= 1'b0;
            ack     <= gnt;
            err     <= 1'b0;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            mem_EN  <= 1'b0;
            ack     <= gnt;
            err     <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          ack     <= '0;
          err     <= 1'b0;
          gnt     <= '0;
          r_timer <= '0;
          r_state <= S_IDLE;
`ifdef ARB_RR_EN
          r_ptr   <= ~r_ptr;
`endif
        end
        default: begin
          r_state   <= S_IDLE;
          r_timer   <= '0;
          gnt       <= '0;
          ack       <= '0;
          err       <= 1'b0;
          rdata     <= '0;
          mem_EN    <= 1'b0;
          mem_RW    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected responses, a monitor checks acks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, rw;
  logic [5:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  gnt, ack;
  logic        err;
  logic [15:0] rdata;
  logic        mem_EN, mem_RW;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        MFC;

  typedef struct packed {
    logic [1:0]  ack;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.AW(6), .DW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .mem_EN(mem_EN), .mem_RW(mem_RW), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .MFC(MFC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every ack is matched against the oldest expected response.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!(gnt inside {2'b00, 2'b01, 2'b10})) begin
        errors++;
        $display("FAIL gnt_onehot act=%b exp=onehot_or_zero", gnt);
      end
      if (ack !== 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack act=%b exp=none", ack);
        end else begin
          exp_t e, a;
          e = exp_q.pop_front();
          a = '{ack: ack, err: err, rdata: rdata};
          if (a !== e) begin
            errors++;
            $display("FAIL ack_resp act=%h exp=%h", a, e);
          end
        end
        chk("ack_in_gnt", 32'(ack & ~gnt), 32'd0);
      end else if (err !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL err_without_ack act=%b exp=0", err);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Caller sets req/rw/addr/wdata at a negedge; this tracks one access through to its RESP cycle.
  task automatic run_access(input string tag, input logic [1:0] eg, input logic erw,
                            input logic [5:0] ea, input logic [15:0] ewd, input int ewait,
                            input int mfc_at, input logic [15:0] md, input int elen,
                            input logic eerr, input logic [15:0] erd, input bit drop);
    int w, n;
    exp_q.push_back('{ack: eg, err: eerr, rdata: erd});
    w = 0;
    while (mem_EN !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_start_latency"}, 32'(w), 32'(ewait));
    if (mem_EN !== 1'b1) return;
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_mem_RW"}, 32'(mem_RW), 32'(erw));
    if (!erw) chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(ewd));
    n = 0;
    while (mem_EN === 1'b1 && n < 300) begin
      n++;
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(ea));
      MFC       = (n == mfc_at);
      mem_rdata = md;
      if (drop && n == 1) begin
        req    = 2'b00;
        rw     = ~rw;
        addr0  = ~ea;
        addr1  = ~ea;
        wdata0 = ~ewd;
        wdata1 = ~ewd;
      end
      @(negedge clk);
    end
    MFC = 1'b0;
    chk({tag, "_en_cycles"}, 32'(n), 32'(elen));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g3 [4];
    rst_n = 1'b0; req = '0; rw = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; mem_rdata = '0; MFC = 1'b0;
    #12;
    chk("reset_outs", {gnt, ack, err, mem_EN, mem_RW}, 32'd0);
    chk("reset_data", {mem_addr, mem_wdata}, 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // MFC outside ACCESS must do nothing
    MFC = 1'b1;
    idle(3);
    chk("idle_mfc_en", {30'd0, mem_EN, ack != 2'b00}, 32'd0);
    MFC = 1'b0;
    idle(1);

    // 1: requester 0 read, MFC in second ACCESS cycle
    req = 2'b01; rw = 2'b01; addr0 = 6'h05;
    run_access("t1", 2'b01, 1'b1, 6'h05, 16'h0, 1, 2, 16'hABCD, 2, 1'b0, 16'hABCD, 1'b0);
    req = 2'b00; idle(3);

    // 2: requester 1 write, MFC immediately; rdata must not change
    req = 2'b10; rw = 2'b00; addr1 = 6'h03; wdata1 = 16'h1234;
    run_access("t2", 2'b10, 1'b0, 6'h03, 16'h1234, 1, 1, 16'hFFFF, 1, 1'b0, 16'hABCD, 1'b0);
    req = 2'b00; idle(3);

    // 3: both requesting for four back-to-back accesses
`ifdef ARB_RR_EN
    g3 = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    g3 = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    req = 2'b11; rw = 2'b11; addr0 = 6'h0A; addr1 = 6'h0B;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] d;
      d = 16'h1111 * 16'(i + 1);
      run_access("t3", g3[i], 1'b1, g3[i][1] ? 6'h0B : 6'h0A, 16'h0, (i == 0) ? 1 : 2,
                 1, d, 1, 1'b0, d, 1'b0);
    end
    req = 2'b00; idle(3);

    // 4: no MFC -> timeout after 15 ACCESS cycles, rdata kept
    req = 2'b01; rw = 2'b01; addr0 = 6'h07;
    run_access("t4", 2'b01, 1'b1, 6'h07, 16'h0, 1, 0, 16'h5555, 15, 1'b1, 16'h4444, 1'b0);
    req = 2'b00; idle(3);

    // 4b: MFC in the timeout cycle is a normal completion
    req = 2'b01; rw = 2'b01; addr0 = 6'h08;
    run_access("t4b", 2'b01, 1'b1, 6'h08, 16'h0, 1, 15, 16'h6666, 15, 1'b0, 16'h6666, 1'b0);
    req = 2'b00; idle(3);

    // 5: reset during ACCESS aborts with no ack
    req = 2'b01; rw = 2'b01; addr0 = 6'h09;
    idle(2);
    chk("t5_in_access", 32'(mem_EN), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {gnt, ack, err, mem_EN, mem_RW}, 32'd0);
    chk("t5_rst_data", {mem_addr, mem_wdata}, 32'd0);
    chk("t5_rst_rdata", 32'(rdata), 32'd0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    req = 2'b01; rw = 2'b01; addr0 = 6'h11;
    run_access("t5", 2'b01, 1'b1, 6'h11, 16'h0, 1, 2, 16'h9999, 2, 1'b0, 16'h9999, 1'b0);
    req = 2'b00; idle(3);

    // 6: req dropped and inputs changed mid-ACCESS; latched values kept
    req = 2'b01; rw = 2'b01; addr0 = 6'h12;
    run_access("t6", 2'b01, 1'b1, 6'h12, 16'h0, 1, 3, 16'h7777, 3, 1'b0, 16'h7777, 1'b1);
    req = 2'b00; idle(4);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
